sap_sequencer: RTL and testbench

//  Fetch/decode/execute sequencer for the SAP-1 datapath (PC, MAR, RAM, reg A/B, ALU, output reg).

---
 rtl/sap_pkg.sv | 40 ++++
 rtl/sap_microcode_rom.sv | 88 ++++++++
 rtl/sap_sequencer.sv | 135 +++++++++++++
 tb/tb_sap_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 sequencer: opcodes, T-state encodings, control-word bit positions.
// Purely declarative; no logic.
package sap_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_STA = 8'h04;
  localparam logic [7:0] OP_LDI = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_JC  = 8'h07;
  localparam logic [7:0] OP_JZ  = 8'h08;
  localparam logic [7:0] OP_OUT = 8'h09;
  localparam logic [7:0] OP_HLT = 8'h0F;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam int CW_MAR_IN    = 0;
  localparam int CW_RAM_IN    = 1;
  localparam int CW_RAM_OUT   = 2;
  localparam int CW_INSTR_OUT = 3;
  localparam int CW_A_IN      = 4;
  localparam int CW_A_OUT     = 5;
  localparam int CW_ALU_OUT   = 6;
  localparam int CW_ALU_SUB   = 7;
  localparam int CW_B_IN      = 8;
  localparam int CW_OUT_IN    = 9;
  localparam int CW_PC_INC    = 10;
  localparam int CW_PC_OUT    = 11;
  localparam int CW_PC_JUMP   = 12;
  localparam int CW_W         = 13;

  typedef logic [CW_W-1:0] ctl_word_t;

endpackage

// File: rtl/sap_microcode_rom.sv
// Microcode table: {opcode, tstate, C, Z} -> {control word, last_step}.
// Latency: combinational. Backpressure: none; the caller decides when to advance.
// last_step is meaningful from T2 on; the fetch-phase exit is decided by the sequencer.
module sap_microcode_rom
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          tstate,
  input  logic                flag_c,
  input  logic                flag_z,
  output ctl_word_t           ctl,
  output logic                last_step
);

  always_comb begin
    ctl       = '0;
    last_step = 1'b0;
    case (tstate)
      T0: begin
        ctl[CW_PC_OUT] = 1'b1;
        ctl[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        ctl[CW_RAM_OUT] = 1'b1;
        ctl[CW_PC_INC]  = 1'b1;
      end
      default: begin
        last_step = 1'b1;
        case (opcode)
          OPCODE_W'(OP_LDA), OPCODE_W'(OP_STA): begin
            if (tstate == T2) begin
              ctl[CW_INSTR_OUT] = 1'b1;
              ctl[CW_MAR_IN]    = 1'b1;
              last_step         = 1'b0;
            end else if (opcode == OPCODE_W'(OP_LDA)) begin
              ctl[CW_RAM_OUT] = 1'b1;
              ctl[CW_A_IN]    = 1'b1;
            end else begin
              ctl[CW_A_OUT]  = 1'b1;
              ctl[CW_RAM_IN] = 1'b1;
            end
          end
          OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
            if (tstate == T2) begin
              ctl[CW_INSTR_OUT] = 1'b1;
              ctl[CW_MAR_IN]    = 1'b1;
              last_step         = 1'b0;
            end else if (tstate == T3) begin
              ctl[CW_RAM_OUT] = 1'b1;
              ctl[CW_B_IN]    = 1'b1;
              last_step       = 1'b0;
            end else begin
              ctl[CW_ALU_OUT] = 1'b1;
              ctl[CW_A_IN]    = 1'b1;
              ctl[CW_ALU_SUB] = (opcode == OPCODE_W'(OP_SUB));
            end
          end
          OPCODE_W'(OP_LDI): begin
            ctl[CW_INSTR_OUT] = 1'b1;
            ctl[CW_A_IN]      = 1'b1;
          end
          OPCODE_W'(OP_JMP): begin
            ctl[CW_INSTR_OUT] = 1'b1;
            ctl[CW_PC_JUMP]   = 1'b1;
          end
          OPCODE_W'(OP_JC): begin
            ctl[CW_INSTR_OUT] = flag_c;
            ctl[CW_PC_JUMP]   = flag_c;
          end
          OPCODE_W'(OP_JZ): begin
            ctl[CW_INSTR_OUT] = flag_z;
            ctl[CW_PC_JUMP]   = flag_z;
          end
          OPCODE_W'(OP_OUT): begin
            ctl[CW_A_OUT]  = 1'b1;
            ctl[CW_OUT_IN] = 1'b1;
          end
          // Halt parks in T2; the sequencer's halt register freezes the counter.
          OPCODE_W'(OP_HLT): last_step = 1'b0;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/sap_sequencer.sv
// SAP-1 fetch/decode/execute sequencer: owns tstate, IR, C/Z flags and halt; drives all bus strobes.
// Latency: strobes are combinational from registered state; 2..5 cycles per instruction.
// Backpressure: none by default; with SAP_SEQ_SINGLE_STEP_EN, i_step gates every state update.
module sap_sequencer
  import sap_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
`ifdef SAP_SEQ_SINGLE_STEP_EN
  input  logic                         i_step,
`endif
  input  logic [OPCODE_W+DATA_W-1:0]   i_instruction,
  input  logic                         i_flag_overflow,
  input  logic                         i_flag_zero,
  output logic [2:0]                   o_tstate,
  output logic                         o_halt,
  output logic                         o_memory_address_in,
  output logic                         o_ram_in,
  output logic                         o_ram_out,
  output logic                         o_instruction_out,
  output logic                         o_register_a_in,
  output logic                         o_register_a_out,
  output logic                         o_alu_out,
  output logic                         o_alu_subtract,
  output logic                         o_register_b_in,
  output logic                         o_register_output_in,
  output logic                         o_program_counter_increment,
  output logic                         o_program_counter_out,
  output logic                         o_program_counter_jump
);

  logic [2:0]                 tstate_q, tstate_d;
  logic [OPCODE_W+DATA_W-1:0] ir_q, ir_d;
  logic                       c_q, c_d, z_q, z_d;
  logic                       halt_q, halt_d;
  logic                       advance;
  logic [OPCODE_W-1:0]        ir_op, in_op;
  logic                       in_has_exec;
  ctl_word_t                  rom_ctl, ctl;
  logic                       rom_last;

`ifdef SAP_SEQ_SINGLE_STEP_EN
  assign advance = i_step;
`else
  assign advance = 1'b1;
`endif

  assign ir_op = ir_q[OPCODE_W+DATA_W-1:DATA_W];
  assign in_op = i_instruction[OPCODE_W+DATA_W-1:DATA_W];

  // The operand is only ever placed on the bus by the datapath's copy of the RAM word.
  logic unused_operand;
  assign unused_operand = ^ir_q[DATA_W-1:0];

  sap_microcode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
    .opcode    (ir_op),
    .tstate    (tstate_q),
    .flag_c    (c_q),
    .flag_z    (z_q),
    .ctl       (rom_ctl),
    .last_step (rom_last)
  );

  // NOP and unknown opcodes end after fetch, so T1 must look at the word being loaded.
  always_comb begin
    case (in_op)
      OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_STA),
      OPCODE_W'(OP_LDI), OPCODE_W'(OP_JMP), OPCODE_W'(OP_JC),  OPCODE_W'(OP_JZ),
      OPCODE_W'(OP_OUT), OPCODE_W'(OP_HLT): in_has_exec = 1'b1;
      default:                              in_has_exec = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tstate_q <= T0;
      ir_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      ir_q     <= ir_d;
      c_q      <= c_d;
      z_q      <= z_d;
      halt_q   <= halt_d;
    end
  end

  always_comb begin
    tstate_d = tstate_q;
    ir_d     = ir_q;
    c_d      = c_q;
    z_d      = z_q;
    halt_d   = halt_q;
    if (advance && !halt_q) begin
      if (tstate_q == T1) begin
        ir_d     = i_instruction;
        tstate_d = in_has_exec ? T2 : T0;
        halt_d   = (in_op == OPCODE_W'(OP_HLT));
      end else begin
        tstate_d = rom_last ? T0 : tstate_q + 3'd1;
        // Only ADD/SUB ever reach T4.
        if (tstate_q == T4) begin
          c_d = i_flag_overflow;
          z_d = i_flag_zero;
        end
      end
    end
  end

  always_comb begin
    ctl = (i_reset || halt_q) ? '0 : rom_ctl;
  end

  assign o_tstate                    = tstate_q;
  assign o_halt                      = halt_q;
  assign o_memory_address_in         = ctl[CW_MAR_IN];
  assign o_ram_in                    = ctl[CW_RAM_IN];
  assign o_ram_out                   = ctl[CW_RAM_OUT];
  assign o_instruction_out           = ctl[CW_INSTR_OUT];
  assign o_register_a_in             = ctl[CW_A_IN];
  assign o_register_a_out            = ctl[CW_A_OUT];
  assign o_alu_out                   = ctl[CW_ALU_OUT];
  assign o_alu_subtract              = ctl[CW_ALU_SUB];
  assign o_register_b_in             = ctl[CW_B_IN];
  assign o_register_output_in        = ctl[CW_OUT_IN];
  assign o_program_counter_increment = ctl[CW_PC_INC];
  assign o_program_counter_out       = ctl[CW_PC_OUT];
  assign o_program_counter_jump      = ctl[CW_PC_JUMP];

endmodule

// File: tb/tb_sap_sequencer.sv
// Scoreboard bench for sap_sequencer: directed programs push per-cycle expectations, a monitor checks.
module tb_sap_sequencer;

  localparam logic [12:0] MAR    = 13'h0001;
  localparam logic [12:0] RAMIN  = 13'h0002;
  localparam logic [12:0] RAMOUT = 13'h0004;
  localparam logic [12:0] IOUT   = 13'h0008;
  localparam logic [12:0] AIN    = 13'h0010;
  localparam logic [12:0] AOUT   = 13'h0020;
  localparam logic [12:0] ALUOUT = 13'h0040;
  localparam logic [12:0] SUB    = 13'h0080;
  localparam logic [12:0] BIN    = 13'h0100;
  localparam logic [12:0] OIN    = 13'h0200;
  localparam logic [12:0] PCINC  = 13'h0400;
  localparam logic [12:0] PCOUT  = 13'h0800;
  localparam logic [12:0] JUMP   = 13'h1000;
  localparam logic [12:0] NONE   = 13'h0000;

  typedef struct {
    string       tag;
    logic [2:0]  ts;
    logic [12:0] ctl;
    logic        hlt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        fo = 1'b0;
  logic        fz = 1'b0;
`ifdef SAP_SEQ_SINGLE_STEP_EN
  logic        stp = 1'b1;
`endif
  logic [2:0]  d_ts;
  logic        d_halt;
  logic        s_mar, s_ramin, s_ramout, s_iout, s_ain, s_aout, s_aluout, s_sub;
  logic        s_bin, s_oin, s_pcinc, s_pcout, s_jump;
  logic [12:0] d_ctl;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event mon_ev;

  always #5 clk = ~clk;

  sap_sequencer dut (
    .i_clock                     (clk),
    .i_reset                     (rst),
`ifdef SAP_SEQ_SINGLE_STEP_EN
    .i_step                      (stp),
`endif
    .i_instruction               (instr),
    .i_flag_overflow             (fo),
    .i_flag_zero                 (fz),
    .o_tstate                    (d_ts),
    .o_halt                      (d_halt),
    .o_memory_address_in         (s_mar),
    .o_ram_in                    (s_ramin),
    .o_ram_out                   (s_ramout),
    .o_instruction_out           (s_iout),
    .o_register_a_in             (s_ain),
    .o_register_a_out            (s_aout),
    .o_alu_out                   (s_aluout),
    .o_alu_subtract              (s_sub),
    .o_register_b_in             (s_bin),
    .o_register_output_in        (s_oin),
    .o_program_counter_increment (s_pcinc),
    .o_program_counter_out       (s_pcout),
    .o_program_counter_jump      (s_jump)
  );

  assign d_ctl = {s_jump, s_pcout, s_pcinc, s_oin, s_bin, s_sub, s_aluout,
                  s_aout, s_ain, s_iout, s_ramout, s_ramin, s_mar};

  task automatic expect_now(input string tag, input logic [2:0] ts, input logic [12:0] ctl,
                            input logic hlt);
    exp_t e;
    e.tag = tag; e.ts = ts; e.ctl = ctl; e.hlt = hlt;
    exp_q.push_back(e);
  endtask

  // Describes one cycle: inputs held during it and the outputs expected in it.
  task automatic step(input string tag, input logic [2:0] ts, input logic [12:0] ctl,
                      input logic hlt, input logic [15:0] ins, input logic o, input logic z);
    instr = ins; fo = o; fz = z;
    expect_now(tag, ts, ctl, hlt);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (d_ts !== e.ts || d_ctl !== e.ctl || d_halt !== e.hlt) begin
          n_fail++;
          $display("FAIL %s: got tstate=%0d ctl=%h halt=%b, want tstate=%0d ctl=%h halt=%b",
                   e.tag, d_ts, d_ctl, d_halt, e.ts, e.ctl, e.hlt);
        end
      end
    end
  end

  initial begin : stimulus
    @(posedge clk); #1;
    step("reset", 3'd0, NONE, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // LDA 05
    step("lda_t0", 3'd0, PCOUT | MAR,   1'b0, 16'h0000, 1'b0, 1'b0);
    step("lda_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0105, 1'b0, 1'b0);
    step("lda_t2", 3'd2, IOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("lda_t3", 3'd3, RAMOUT | AIN,  1'b0, 16'h0000, 1'b0, 1'b0);

    // ADD with carry, then JC taken
    step("add_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("add_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0210, 1'b0, 1'b0);
    step("add_t2", 3'd2, IOUT | MAR,     1'b0, 16'h0000, 1'b0, 1'b0);
    step("add_t3", 3'd3, RAMOUT | BIN,   1'b0, 16'h0000, 1'b0, 1'b0);
    step("add_t4", 3'd4, ALUOUT | AIN,   1'b0, 16'h0000, 1'b1, 1'b0);
    step("jc1_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("jc1_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0702, 1'b0, 1'b0);
    step("jc1_t2", 3'd2, IOUT | JUMP,    1'b0, 16'h0000, 1'b0, 1'b0);

    // ADD without carry, then JC not taken (3 cycles, silent T2)
    step("add2_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b1, 1'b1);
    step("add2_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0210, 1'b1, 1'b1);
    step("add2_t2", 3'd2, IOUT | MAR,     1'b0, 16'h0000, 1'b1, 1'b1);
    step("add2_t3", 3'd3, RAMOUT | BIN,   1'b0, 16'h0000, 1'b1, 1'b1);
    step("add2_t4", 3'd4, ALUOUT | AIN,   1'b0, 16'h0000, 1'b0, 1'b0);
    step("jc0_t0",  3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b1, 1'b1);
    step("jc0_t1",  3'd1, RAMOUT | PCINC, 1'b0, 16'h0702, 1'b1, 1'b1);
    step("jc0_t2",  3'd2, NONE,           1'b0, 16'h0000, 1'b1, 1'b1);

    // SUB sets Z, NOP holds it, JZ taken
    step("sub_t0", 3'd0, PCOUT | MAR,        1'b0, 16'h0000, 1'b0, 1'b0);
    step("sub_t1", 3'd1, RAMOUT | PCINC,     1'b0, 16'h0333, 1'b0, 1'b0);
    step("sub_t2", 3'd2, IOUT | MAR,         1'b0, 16'h0000, 1'b0, 1'b0);
    step("sub_t3", 3'd3, RAMOUT | BIN,       1'b0, 16'h0000, 1'b0, 1'b0);
    step("sub_t4", 3'd4, ALUOUT | AIN | SUB, 1'b0, 16'h0000, 1'b0, 1'b1);
    step("nop_t0", 3'd0, PCOUT | MAR,        1'b0, 16'h0000, 1'b0, 1'b0);
    step("nop_t1", 3'd1, RAMOUT | PCINC,     1'b0, 16'h0000, 1'b0, 1'b0);
    step("jz_t0",  3'd0, PCOUT | MAR,        1'b0, 16'h0000, 1'b0, 1'b0);
    step("jz_t1",  3'd1, RAMOUT | PCINC,     1'b0, 16'h0804, 1'b0, 1'b0);
    step("jz_t2",  3'd2, IOUT | JUMP,        1'b0, 16'h0000, 1'b0, 1'b0);
    // C was cleared by SUB, so JC falls through
    step("jcz_t0", 3'd0, PCOUT | MAR,        1'b0, 16'h0000, 1'b0, 1'b0);
    step("jcz_t1", 3'd1, RAMOUT | PCINC,     1'b0, 16'h0701, 1'b0, 1'b0);
    step("jcz_t2", 3'd2, NONE,               1'b0, 16'h0000, 1'b0, 1'b0);

    // STA, LDI, JMP, OUT execute steps
    step("sta_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("sta_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h040E, 1'b0, 1'b0);
    step("sta_t2", 3'd2, IOUT | MAR,     1'b0, 16'h0000, 1'b0, 1'b0);
    step("sta_t3", 3'd3, AOUT | RAMIN,   1'b0, 16'h0000, 1'b0, 1'b0);
    step("ldi_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("ldi_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0507, 1'b0, 1'b0);
    step("ldi_t2", 3'd2, IOUT | AIN,     1'b0, 16'h0000, 1'b0, 1'b0);
    step("jmp_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("jmp_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0603, 1'b0, 1'b0);
    step("jmp_t2", 3'd2, IOUT | JUMP,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("out_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("out_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0900, 1'b0, 1'b0);
    step("out_t2", 3'd2, AOUT | OIN,     1'b0, 16'h0000, 1'b0, 1'b0);

    // HLT: frozen in T2 regardless of inputs, cleared only by reset
    step("hlt_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("hlt_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0F00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("hlt_hold", 3'd2, NONE, 1'b1, 16'h0210, i[0], i[1]);
    rst = 1'b1;
    expect_now("hlt_rst", 3'd0, NONE, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_hlt_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("post_hlt_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset between edges during ADD T3
    step("abort_t0", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("abort_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0210, 1'b0, 1'b0);
    step("abort_t2", 3'd2, IOUT | MAR,     1'b0, 16'h0000, 1'b0, 1'b0);
    expect_now("abort_t3", 3'd3, RAMOUT | BIN, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    expect_now("abort_rst", 3'd0, NONE, 1'b0);
    #1 -> mon_ev;
    @(posedge clk); #1;
    rst = 1'b0;
    step("a5_t0",   3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);
    step("a5_t1",   3'd1, RAMOUT | PCINC, 1'b0, 16'hA500, 1'b0, 1'b0);
    step("a5_next", 3'd0, PCOUT | MAR,    1'b0, 16'h0000, 1'b0, 1'b0);

`ifdef SAP_SEQ_SINGLE_STEP_EN
    // Now in T1: holding step low must not load the HLT word offered meanwhile
    stp = 1'b0;
    for (int i = 0; i < 10; i++)
      step("ss_hold_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0F00, 1'b1, 1'b1);
    stp = 1'b1;
    step("ss_t1", 3'd1, RAMOUT | PCINC, 1'b0, 16'h0507, 1'b0, 1'b0);
    stp = 1'b0;
    for (int i = 0; i < 3; i++)
      step("ss_hold_t2", 3'd2, IOUT | AIN, 1'b0, 16'h0F00, 1'b0, 1'b0);
    stp = 1'b1;
    step("ss_t2", 3'd2, IOUT | AIN,  1'b0, 16'h0000, 1'b0, 1'b0);
    step("ss_t0", 3'd0, PCOUT | MAR, 1'b0, 16'h0000, 1'b0, 1'b0);
`endif

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
